// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode 7-segment driver with a double-buffered digit store.
// The shadow bank is copied to the active bank only at a frame boundary.
module seven_seg_scanner #(
   parameter int DIGITS    = 4,
   parameter int PRESCALE  = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [$clog2(DIGITS)-1:0] wr_addr,
   input  logic [3:0]                wr_data,
   input  logic                      wr_dp,
   input  logic                      wr_blank,
   input  logic                      commit,
   output logic                      pending,
   output logic                      commit_done,
   output logic                      frame_start,
   output logic [DIGITS-1:0]         an,
   output logic [6:0]                seg,
   output logic                      dp
);

   localparam int AW = $clog2(DIGITS);
   localparam int PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
   localparam logic [AW-1:0] IDX_LAST  = AW'(DIGITS - 1);
   localparam logic [AW:0]   NDIG      = (AW + 1)'(DIGITS);

   typedef struct packed {
      logic [3:0] data;
      logic       dp;
      logic       blank;
   } entry_t;

   localparam entry_t ENTRY_RST = '{data: 4'h0, dp: 1'b0, blank: 1'b1};

   entry_t shd_q [DIGITS];
   entry_t act_q [DIGITS];

   logic [PW-1:0]     pcnt_q, pcnt_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic              pending_q, pending_d;
   logic              commit_done_q, frame_start_q;
   logic [DIGITS-1:0] an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic              tick, fb, xfer, wr_ok;

   function automatic logic [6:0] font(input logic [3:0] v);
      case (v)
         4'h0: font = 7'b1000000;
         4'h1: font = 7'b1111001;
         4'h2: font = 7'b0100100;
         4'h3: font = 7'b0110000;
         4'h4: font = 7'b0011001;
         4'h5: font = 7'b0010010;
         4'h6: font = 7'b0000010;
         4'h7: font = 7'b1111000;
         4'h8: font = 7'b0000000;
         4'h9: font = 7'b0010000;
         4'hA: font = 7'b0001000;
         4'hB: font = 7'b0000011;
         4'hC: font = 7'b1000110;
         4'hD: font = 7'b0100001;
         4'hE: font = 7'b0000110;
         default: font = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      tick   = (pcnt_q == PCNT_LAST);
      fb     = tick && (idx_q == IDX_LAST);
      xfer   = fb && pending_q;
      wr_ok  = wr_en && ({1'b0, wr_addr} < NDIG);
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      idx_d  = idx_q;
      if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      pending_d = pending_q;
      if (xfer)        pending_d = 1'b0;
      else if (commit) pending_d = 1'b1;
      // Outputs are decoded from the current scan position and registered below.
      an_d  = '1;
      seg_d = '1;
      dp_d  = 1'b1;
      if ((pcnt_q >= BLANK_END) && !act_q[idx_q].blank) begin
         an_d[idx_q] = 1'b0;
         seg_d       = font(act_q[idx_q].data);
         dp_d        = ~act_q[idx_q].dp;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt_q        <= '0;
         idx_q         <= '0;
         pending_q     <= 1'b0;
         commit_done_q <= 1'b0;
         frame_start_q <= 1'b0;
         an_q          <= '1;
         seg_q         <= '1;
         dp_q          <= 1'b1;
         for (int unsigned k = 0; k < DIGITS; k++) begin
            shd_q[k] <= ENTRY_RST;
            act_q[k] <= ENTRY_RST;
         end
      end else begin
         pcnt_q        <= pcnt_d;
         idx_q         <= idx_d;
         pending_q     <= pending_d;
         commit_done_q <= xfer;
         frame_start_q <= fb;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         // Non-blocking copy takes the pre-write shadow when a write collides with a transfer.
         if (xfer) begin
            for (int unsigned k = 0; k < DIGITS; k++) act_q[k] <= shd_q[k];
         end
         if (wr_ok) shd_q[wr_addr] <= '{data: wr_data, dp: wr_dp, blank: wr_blank};
      end
   end

   assign pending     = pending_q;
   assign commit_done = commit_done_q;
   assign frame_start = frame_start_q;
   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed sequences and a table of digit vectors,
// plus random traffic compared every cycle against a time-indexed reference model.
module tb_seven_seg_scanner;

   localparam int D = 4;
   localparam int P = 8;
   localparam int B = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [3:0] wr_data = '0;
   logic       wr_dp = 1'b0;
   logic       wr_blank = 1'b0;
   logic       commit = 1'b0;
   logic       pending, commit_done, frame_start;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   always #5 clk = ~clk;

   seven_seg_scanner #(.DIGITS(D), .PRESCALE(P), .BLANK_CYC(B)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_dp(wr_dp), .wr_blank(wr_blank), .commit(commit), .pending(pending),
      .commit_done(commit_done), .frame_start(frame_start), .an(an), .seg(seg), .dp(dp)
   );

   int checks = 0;
   int failures = 0;

   logic [6:0] font_ref [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Reference model: scan position is derived from cycles elapsed since reset.
   int         t;
   logic [3:0] m_sd [D], m_ad [D];
   logic       m_sp [D], m_ap [D], m_sb [D], m_ab [D];
   logic       m_pend;
   logic [3:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp, e_fs, e_cd;
   bit         model_ok = 0;

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         t = 0; m_pend = 1'b0;
         for (int k = 0; k < D; k++) begin
            m_sd[k] = 4'h0; m_sp[k] = 1'b0; m_sb[k] = 1'b1;
            m_ad[k] = 4'h0; m_ap[k] = 1'b0; m_ab[k] = 1'b1;
         end
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_cd = 1'b0;
      end else begin
         int  slot, digit;
         bit  boundary;
         slot     = t % P;
         digit    = (t / P) % D;
         boundary = ((t % (P * D)) == P * D - 1);
         if (slot < B || m_ab[digit]) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         end else begin
            e_an = 4'hF; e_an[digit] = 1'b0;
            e_seg = font_ref[m_ad[digit]];
            e_dp = ~m_ap[digit];
         end
         e_fs = boundary;
         e_cd = boundary && m_pend;
         if (boundary && m_pend) begin
            m_ad = m_sd; m_ap = m_sp; m_ab = m_sb;
            m_pend = 1'b0;
         end else if (commit) begin
            m_pend = 1'b1;
         end
         if (wr_en && wr_addr < D) begin
            m_sd[wr_addr] = wr_data; m_sp[wr_addr] = wr_dp; m_sb[wr_addr] = wr_blank;
         end
         t++;
      end
      model_ok = 1;
   end

   initial forever begin
      @(negedge clk);
      if (model_ok) begin
         checks++;
         if ({an, seg, dp, frame_start, commit_done, pending} !==
             {e_an, e_seg, e_dp, e_fs, e_cd, m_pend}) begin
            failures++;
            $display("FAIL model t=%0d got an=%b seg=%b dp=%b fs=%b cd=%b pend=%b expected an=%b seg=%b dp=%b fs=%b cd=%b pend=%b",
                     t, an, seg, dp, frame_start, commit_done, pending,
                     e_an, e_seg, e_dp, e_fs, e_cd, m_pend);
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic write(input logic [1:0] a, input logic [3:0] d, input logic p, input logic b);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p; wr_blank = b;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      cyc();
      commit = 1'b0;
   endtask

   task automatic wait_cd(input string nm);
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (commit_done === 1'b1) return;
      end
      checks++; failures++;
      $display("FAIL %s: commit_done not seen within 200 cycles", nm);
   endtask

   task automatic wait_fs(input string nm);
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (frame_start === 1'b1) return;
      end
      checks++; failures++;
      $display("FAIL %s: frame_start not seen within 200 cycles", nm);
   endtask

   typedef struct {
      logic [1:0] addr;
      logic [3:0] data;
      logic       dpv;
      logic       blank;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
   } vec_t;

   vec_t vt [19];

   initial begin
      int fs_cnt, fs_first, fs_last;
      bit bad_an, bad_cd;

      vt[0]  = '{2'd0, 4'h0, 1'b1, 1'b0, 4'b1110, 7'b1000000, 1'b0};
      vt[1]  = '{2'd1, 4'h1, 1'b0, 1'b0, 4'b1101, 7'b1111001, 1'b1};
      vt[2]  = '{2'd2, 4'h2, 1'b0, 1'b0, 4'b1011, 7'b0100100, 1'b1};
      vt[3]  = '{2'd3, 4'h3, 1'b1, 1'b0, 4'b0111, 7'b0110000, 1'b0};
      vt[4]  = '{2'd0, 4'h4, 1'b0, 1'b0, 4'b1110, 7'b0011001, 1'b1};
      vt[5]  = '{2'd1, 4'h5, 1'b0, 1'b0, 4'b1101, 7'b0010010, 1'b1};
      vt[6]  = '{2'd2, 4'h6, 1'b1, 1'b0, 4'b1011, 7'b0000010, 1'b0};
      vt[7]  = '{2'd3, 4'h7, 1'b0, 1'b0, 4'b0111, 7'b1111000, 1'b1};
      vt[8]  = '{2'd0, 4'h8, 1'b0, 1'b0, 4'b1110, 7'b0000000, 1'b1};
      vt[9]  = '{2'd1, 4'h9, 1'b1, 1'b0, 4'b1101, 7'b0010000, 1'b0};
      vt[10] = '{2'd2, 4'hA, 1'b0, 1'b0, 4'b1011, 7'b0001000, 1'b1};
      vt[11] = '{2'd3, 4'hB, 1'b0, 1'b0, 4'b0111, 7'b0000011, 1'b1};
      vt[12] = '{2'd0, 4'hC, 1'b1, 1'b0, 4'b1110, 7'b1000110, 1'b0};
      vt[13] = '{2'd1, 4'hD, 1'b0, 1'b0, 4'b1101, 7'b0100001, 1'b1};
      vt[14] = '{2'd2, 4'hE, 1'b0, 1'b0, 4'b1011, 7'b0000110, 1'b1};
      vt[15] = '{2'd3, 4'hF, 1'b1, 1'b0, 4'b0111, 7'b0001110, 1'b0};
      vt[16] = '{2'd1, 4'h5, 1'b1, 1'b1, 4'b1111, 7'b1111111, 1'b1};
      vt[17] = '{2'd2, 4'h8, 1'b0, 1'b1, 4'b1111, 7'b1111111, 1'b1};
      vt[18] = '{2'd2, 4'hF, 1'b0, 1'b0, 4'b1011, 7'b0001110, 1'b1};

      // Reset: held 3 cycles, display dark, frame_start every 32 cycles.
      rst_n = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      fs_cnt = 0; fs_first = -1; fs_last = -1; bad_an = 0;
      for (int k = 1; k <= 64; k++) begin
         cyc();
         if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) bad_an = 1;
         if (frame_start === 1'b1) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = k;
            fs_last = k;
         end
      end
      chk("reset_dark", {31'd0, bad_an}, 32'd0);
      chk("reset_fs_count", fs_cnt, 2);
      chk("reset_fs_first", fs_first, 32);
      chk("reset_fs_period", fs_last - fs_first, 32);

      // Basic load.
      write(2'd0, 4'h1, 1'b0, 1'b0);
      write(2'd1, 4'hA, 1'b0, 1'b0);
      write(2'd2, 4'h8, 1'b1, 1'b0);
      write(2'd3, 4'hF, 1'b0, 1'b0);
      do_commit();
      wait_cd("load_cd");
      cyc(); chk("load_blank0_k1", an, 4'hF);
      cyc(); chk("load_blank0_k2", an, 4'hF);
      cyc(); chk("load_d0_an", an, 4'b1110); chk("load_d0_seg", seg, 7'b1111001);
      repeat (6) cyc(); chk("load_blank1", an, 4'hF);
      repeat (2) cyc(); chk("load_d1_an", an, 4'b1101); chk("load_d1_seg", seg, 7'b0001000);
      repeat (8) cyc(); chk("load_d2_an", an, 4'b1011); chk("load_d2_seg", seg, 7'b0000000);
      chk("load_d2_dp", dp, 1'b0);
      repeat (8) cyc(); chk("load_d3_an", an, 4'b0111); chk("load_d3_seg", seg, 7'b0001110);
      chk("load_d3_dp", dp, 1'b1);

      // No-tear: shadow change without commit stays invisible.
      write(2'd0, 4'h7, 1'b0, 1'b0);
      repeat (64) cyc();
      wait_fs("notear_sync");
      repeat (3) cyc(); chk("notear_hold", seg, 7'b1111001);
      do_commit();
      wait_cd("notear_cd");
      repeat (3) cyc(); chk("notear_new", seg, 7'b1111000); chk("notear_an", an, 4'b1110);

      // Commit arriving in the boundary cycle with nothing pending waits a frame.
      wait_fs("late_sync");
      repeat (31) cyc();
      commit = 1'b1;
      cyc();
      commit = 1'b0;
      chk("late_fs", frame_start, 1'b1);
      chk("late_no_cd", commit_done, 1'b0);
      chk("late_pend", pending, 1'b1);
      repeat (32) cyc();
      chk("late_cd", commit_done, 1'b1);
      chk("late_pend_clr", pending, 1'b0);

      // Boundary collision: write in the transfer cycle stays in shadow.
      wait_fs("coll_sync");
      commit = 1'b1;
      cyc();
      commit = 1'b0;
      chk("coll_pend_rise", pending, 1'b1);
      repeat (30) cyc();
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'h5; wr_dp = 1'b0; wr_blank = 1'b0;
      cyc();
      wr_en = 1'b0;
      chk("coll_fs", frame_start, 1'b1);
      chk("coll_cd", commit_done, 1'b1);
      chk("coll_pend_fall", pending, 1'b0);
      repeat (27) cyc(); chk("coll_old_an", an, 4'b0111); chk("coll_old_seg", seg, 7'b0001110);
      do_commit();
      wait_cd("coll_cd2");
      repeat (27) cyc(); chk("coll_new_seg", seg, 7'b0010010);

      // Mid-frame reset discards a pending transfer.
      write(2'd1, 4'h3, 1'b0, 1'b0);
      do_commit();
      chk("midrst_pend", pending, 1'b1);
      rst_n = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
      chk("midrst_pend_clr", pending, 1'b0);
      bad_an = 0; bad_cd = 0;
      for (int k = 0; k < 70; k++) begin
         cyc();
         if (an !== 4'hF) bad_an = 1;
         if (commit_done !== 1'b0) bad_cd = 1;
      end
      chk("midrst_dark", {31'd0, bad_an}, 32'd0);
      chk("midrst_no_cd", {31'd0, bad_cd}, 32'd0);

      // Table of single-digit updates.
      for (int i = 0; i < 19; i++) begin
         write(vt[i].addr, vt[i].data, vt[i].dpv, vt[i].blank);
         do_commit();
         wait_cd($sformatf("vec%0d_cd", i));
         repeat (3 + 8 * int'(vt[i].addr)) cyc();
         chk($sformatf("vec%0d_an", i), an, vt[i].e_an);
         chk($sformatf("vec%0d_seg", i), seg, vt[i].e_seg);
         chk($sformatf("vec%0d_dp", i), dp, vt[i].e_dp);
      end

      // Random traffic, checked by the reference model each cycle.
      for (int i = 0; i < 2500; i++) begin
         rst_n    = ($urandom_range(0, 999) != 0);
         wr_en    = ($urandom_range(0, 3) == 0);
         wr_addr  = 2'($urandom_range(0, 3));
         wr_data  = 4'($urandom_range(0, 15));
         wr_dp    = 1'($urandom_range(0, 1));
         wr_blank = ($urandom_range(0, 3) == 0);
         commit   = ($urandom_range(0, 24) == 0);
         cyc();
      end
      rst_n = 1'b1; wr_en = 1'b0; commit = 1'b0;
      repeat (4) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
